// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit for the execute stage.
// The result is computed when an operation is accepted and held in p_hi/p_lo,
// then committed to HI/LO after a fixed busy period so the hazard logic sees
// the same latency as an iterative unit.
// Optional build macro: MDU_DIV_ZERO_GUARD_EN (div/divu by zero is dropped
// instead of running; HI/LO keep their values and busy never rises).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,   // legal range 1..15
    parameter int DIV_CYCLES  = 10   // legal range 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_control,
    input  logic        md_write,
    input  logic        hilo_sel,
    input  logic        mfc,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    // md_control[1] selects divide, md_control[0] selects the signed flavour
    logic        is_div;
    logic        is_signed;

    logic [63:0] mul_a_ext;
    logic [63:0] mul_b_ext;
    logic [63:0] mul_prod;

    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] div_q;
    logic [31:0] div_r;

    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic        div_blocked;
    logic        accept;
    logic        mt_write;
    logic        commit;

    assign is_div    = md_control[1];
    assign is_signed = md_control[0];
    assign b_zero    = (b == 32'd0);

`ifdef MDU_DIV_ZERO_GUARD_EN
    assign div_blocked = is_div & b_zero;
`else
    assign div_blocked = 1'b0;
`endif

    // start only matters in IDLE; it always wins over md_write there
    assign accept   = (state == IDLE) & start & ~div_blocked;
    assign mt_write = (state == IDLE) & md_write & ~start;

    // the counter hits 1 on the last busy cycle; <= guards against a stray 0
    assign commit   = (state != IDLE) & (cnt <= 4'd1);

    assign busy     = (state != IDLE);
    assign md_out   = mfc ? hi : lo;

    // Multiply: sign- or zero-extend to 64 bits so a single product covers both
    always_comb begin
        if (is_signed) begin
            mul_a_ext = {{32{a[31]}}, a};
            mul_b_ext = {{32{b[31]}}, b};
        end else begin
            mul_a_ext = {32'd0, a};
            mul_b_ext = {32'd0, b};
        end
        mul_prod = mul_a_ext * mul_b_ext;
    end

    // Divide: work on magnitudes, then fix signs (quotient truncates toward
    // zero, remainder follows the dividend); 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0 without special casing
    always_comb begin
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        if (b_zero) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        if (b_zero) begin
            div_q = 32'hFFFF_FFFF;
            div_r = a;
        end else begin
            div_q = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
            div_r = a_neg ? (~r_mag + 32'd1) : r_mag;
        end
    end

    // Select the result that gets parked in the pending registers
    always_comb begin
        if (is_div) begin
            res_hi = div_r;
            res_lo = div_q;
        end else begin
            res_hi = mul_prod[63:32];
            res_lo = mul_prod[31:0];
        end
    end

    // Sequencer: accept an operation, count down the busy period, return to IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        p_hi  <= res_hi;
                        p_lo  <= res_lo;
                        cnt   <= is_div ? DIV_LOAD : MULT_LOAD;
                        state <= is_div ? DIV : MULT;
                    end
                end
                MULT, DIV: begin
                    if (commit) begin
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else begin
                        cnt   <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end
            endcase
        end
    end

    // HI/LO: written by a commit or by mthi/mtlo while idle, otherwise held
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (commit) begin
            hi <= p_hi;
            lo <= p_lo;
        end else if (mt_write) begin
            if (hilo_sel) begin
                hi <= a;
            end else begin
                lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit.
// Expected HI/LO and busy length are pushed when an operation is issued; a
// monitor pops and compares when busy falls. Honours MDU_DIV_ZERO_GUARD_EN.
`timescale 1ns/1ps
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
`ifdef MDU_DIV_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  md_control;
    logic        md_write;
    logic        hilo_sel;
    logic        mfc;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .md_control(md_control),
        .md_write(md_write), .hilo_sel(hilo_sel), .mfc(mfc), .a(a), .b(b),
        .busy(busy), .hi(hi), .lo(lo), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Architectural reference: returns {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint          sx = longint'(int'(x));
        longint          sy = longint'(int'(y));
        int              q;
        int              r;
        case (op)
            2'b00: return ux * uy;
            2'b01: return 64'(sx * sy);
            2'b10: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = int'(x) / int'(y);
                r = int'(x) % int'(y);
                return {32'(r), 32'(q)};
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                                 input logic w, input logic sel);
        start      = s;
        md_control = op;
        a          = x;
        b          = y;
        md_write   = w;
        hilo_sel   = sel;
        @(posedge clk);
        #1;
        start    = 1'b0;
        md_write = 1'b0;
    endtask

    // Issue an operation, queue its expected commit and advance the model
    task automatic issueOp(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y, input logic w);
        logic [63:0] r;
        if (op[1] && y == 32'd0 && GUARD) begin
            applyStimulus(1'b1, op, x, y, w, 1'b1);
            return;
        end
        r = refResult(op, x, y);
        sb_q.push_back('{r[63:32], r[31:0], op[1] ? DIV_N : MULT_N});
        model_hi = r[63:32];
        model_lo = r[31:0];
        applyStimulus(1'b1, op, x, y, w, 1'b1);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) checkOutput({name, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic mtWrite(input logic [31:0] x, input logic sel);
        applyStimulus(1'b0, 2'b00, x, 32'd0, 1'b1, sel);
        if (sel) model_hi = x; else model_lo = x;
    endtask

    // Monitor: on every busy fall, pop the scoreboard and compare
    initial begin : monitor
        logic prev_busy;
        int   busy_run;
        exp_t e;
        prev_busy = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                prev_busy = 1'b0;
                busy_run  = 0;
            end else begin
                if (busy) begin
                    busy_run++;
                end else if (prev_busy) begin
                    checkOutput("commit_expected", {31'd0, sb_q.size() != 0}, 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        checkOutput("commit_hi", hi, e.hi);
                        checkOutput("commit_lo", lo, e.lo);
                        checkOutput("busy_cycles", 32'(busy_run), 32'(e.cycles));
                    end
                    busy_run = 0;
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] x;
        logic [31:0] y;
        logic [1:0]  op;
        int          seen;

        reset = 1'b1; start = 1'b0; md_control = 2'b00; md_write = 1'b0;
        hilo_sel = 1'b0; mfc = 1'b0; a = 32'd0; b = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_md_out", md_out, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed mult/multu");
        issueOp(2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0);
        waitIdle("mult");
        checkOutput("mult_hi", hi, 32'hFFFF_FFFF);
        checkOutput("mult_lo", lo, 32'hFFFF_FFFA);
        issueOp(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        waitIdle("multu");
        checkOutput("multu_hi", hi, 32'h0000_0002);
        checkOutput("multu_lo", lo, 32'hFFFF_FFFA);

        $display("[TB] directed div/divu");
        issueOp(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        waitIdle("div");
        checkOutput("div_lo", lo, 32'hFFFF_FFFD);
        checkOutput("div_hi", hi, 32'hFFFF_FFFF);
        issueOp(2'b10, 32'd7, 32'd2, 1'b0);
        waitIdle("divu");
        checkOutput("divu_lo", lo, 32'd3);
        checkOutput("divu_hi", hi, 32'd1);
        issueOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitIdle("div_ovf");
        checkOutput("div_ovf_lo", lo, 32'h8000_0000);
        checkOutput("div_ovf_hi", hi, 32'd0);

        $display("[TB] mthi/mtlo and md_out");
        mtWrite(32'h1234_5678, 1'b1);
        checkOutput("mthi_next_cycle", hi, 32'h1234_5678);
        mtWrite(32'h9ABC_DEF0, 1'b0);
        mfc = 1'b1;
        #1;
        checkOutput("md_out_hi", md_out, 32'h1234_5678);
        mfc = 1'b0;
        #1;
        checkOutput("md_out_lo", md_out, 32'h9ABC_DEF0);

        $display("[TB] md_write during busy");
        old_hi = model_hi;
        issueOp(2'b01, 32'd1000, 32'hFFFF_FFF0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b0, 2'b00, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b1);
        checkOutput("busy_hold_hi", hi, old_hi);
        waitIdle("mult_mdw");
        checkOutput("mult_mdw_lo", lo, 32'hFFFF_C180);

        $display("[TB] start with md_write");
        issueOp(2'b00, 32'd6, 32'd7, 1'b1);
        waitIdle("start_mdw");
        checkOutput("start_mdw_hi", hi, 32'd0);
        checkOutput("start_mdw_lo", lo, 32'd42);

        $display("[TB] reset mid divide");
        mtWrite(32'hAAAA_5555, 1'b1);
        mtWrite(32'h5555_AAAA, 1'b0);
        issueOp(2'b11, 32'd100, 32'd7, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        checkOutput("midreset_hi", hi, 32'd0);
        checkOutput("midreset_lo", lo, 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (busy) seen++;
        end
        checkOutput("post_reset_busy_cycles", 32'(seen), 32'd0);
        checkOutput("post_reset_hi", hi, 32'd0);
        checkOutput("post_reset_lo", lo, 32'd0);

        $display("[TB] divu by zero");
        mtWrite(32'h0BAD_F00D, 1'b1);
        mtWrite(32'h0000_1111, 1'b0);
        old_hi = model_hi;
        old_lo = model_lo;
        issueOp(2'b10, 32'h0000_0123, 32'd0, 1'b0);
        if (GUARD) begin
            seen = 0;
            repeat (12) begin
                if (busy) seen++;
                @(posedge clk);
                #1;
            end
            checkOutput("guard_busy_cycles", 32'(seen), 32'd0);
            checkOutput("guard_hi", hi, old_hi);
            checkOutput("guard_lo", lo, old_lo);
        end else begin
            waitIdle("divu_zero");
            checkOutput("divzero_lo", lo, 32'hFFFF_FFFF);
            checkOutput("divzero_hi", hi, 32'h0000_0123);
        end

        $display("[TB] randomized operations");
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'($urandom_range(1, 9));
                2: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                mtWrite(x, 1'($urandom_range(0, 1)));
                mfc = 1'($urandom_range(0, 1));
                #1;
                checkOutput("rand_md_out", md_out, mfc ? model_hi : model_lo);
            end else begin
                issueOp(op, x, y, 1'b0);
                waitIdle("rand_op");
                checkOutput("rand_idle_hi", hi, model_hi);
                checkOutput("rand_idle_lo", lo, model_lo);
            end
        end

        @(negedge clk);
        #1;
        checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative-latency multiply/divide unit in the execute stage of the pipelined MIPS core, directly downstream of the instruction decoder. It consumes the decoder's start, operation-select, HI/LO-write and HI/LO-read controls together with the forwarded rs/rt operands. It owns the HI and LO registers and raises `busy` so hazard logic can stall any HI/LO-using instruction until the result is committed.

## Interface

Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal range 1–15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal range 1–15).

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: begin the multiply/divide selected by `md_control`.
- `md_control` input 2: operation select. 00 = multu, 01 = mult, 10 = divu, 11 = div.
- `md_write` input 1: mthi/mtlo write strobe.
- `hilo_sel` input 1: target of `md_write`. 1 = HI, 0 = LO.
- `mfc` input 1: read select for `md_out`. 1 = HI, 0 = LO.
- `a` input 32: rs operand (dividend / multiplicand / mthi–mtlo data).
- `b` input 32: rt operand (divisor / multiplier).
- `busy` output 1: an operation is in flight.
- `hi` output 32: HI register.
- `lo` output 32: LO register.
- `md_out` output 32: `mfc ? hi : lo`, combinational.

## Operation

- States: IDLE, MULT, DIV. A 4-bit down-counter `cnt` tracks remaining cycles.
- In IDLE with `start`=1:
  - Latch the result into pending registers `p_hi`/`p_lo`.
  - Load `cnt` with MULT_CYCLES or DIV_CYCLES.
  - Enter MULT or DIV.
- In MULT/DIV, decrement `cnt` each cycle. When `cnt`==1, on that edge:
  - Write `p_hi`/`p_lo` to HI/LO.
  - Return to IDLE.
- Arithmetic:
  - multu: `{hi,lo}` = zero-extended 64-bit product.
  - mult: `{hi,lo}` = signed 64-bit product.
  - divu: lo = a/b, hi = a%b (unsigned).
  - div: truncate toward zero; remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- `md_write` in IDLE: write `a` into HI (`hilo_sel`=1) or LO (`hilo_sel`=0) at the next edge.
- Simultaneous `start` and `md_write` in IDLE: `start` wins; `md_write` is ignored.
- While busy:
  - `start` and `md_write` are ignored. Upstream stalls on `MDuse & (busy | start)`.
  - HI/LO hold their old values until commit.
- `reset` (including mid-operation): state = IDLE, `cnt` = 0, `busy` = 0, `hi` = `lo` = 0, `p_hi` = `p_lo` = 0. Any in-flight result is discarded.

## Timing

- `start` sampled at edge T → `busy`=1 during cycles T+1 … T+N, where N = MULT_CYCLES or DIV_CYCLES.
- New HI/LO are visible, with `busy`=0, from cycle T+N+1.
- Back-to-back operations: a new `start` is accepted in the first cycle after `busy` falls.
- `md_write` at edge T → new value visible on `hi`/`lo`/`md_out` from cycle T+1.
- `md_out` has zero latency from `mfc` and from the current HI/LO.
- Reset values of outputs: `busy` = 0, `hi` = 0, `lo` = 0, `md_out` = 0.

## Configuration

- `MDU_DIV_ZERO_GUARD_EN` defined:
  - div/divu with `b`==0 does not enter DIV and leaves HI/LO unchanged.
  - `busy` stays 0.
- `MDU_DIV_ZERO_GUARD_EN` undefined:
  - div/divu with `b`==0 runs the full DIV_CYCLES.
  - It commits lo = 0xFFFFFFFF and hi = `a`.
- Multiply paths are identical in both builds.

## Test plan

- mult with a=0xFFFFFFFE (−2), b=3 → `busy` high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div with a=0xFFFFFFF9 (−7), b=2 → `busy` high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=2 → lo=3, hi=1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles → `mfc`=1 gives `md_out`=0x12345678, `mfc`=0 gives 0x9ABCDEF0. `md_write` pulsed at busy cycle 3 of a mult → ignored; final HI/LO equal the product.
- Assert `reset` at busy cycle 4 of a div (HI/LO preloaded nonzero) → next cycle `busy`=0, hi=lo=0; no later commit occurs.
- divu with b=0 → with `MDU_DIV_ZERO_GUARD_EN`: `busy` never rises and HI/LO keep prior values. Without it: 10 busy cycles, then lo=0xFFFFFFFF, hi=`a`.
